rgb24_stream_packer: RTL

- Consumes the 24-bit RGB pixel stream produced by the output reformatter, one pixel per valid cycle.
- Packs pixels densely, little-endian, into 128-bit words: 16 pixels fill exactly 3 words.
- Delivers the words through a small FIFO with valid/ready handshake, for a DMA/AXI-stream style sink.
- Marks first-of-frame and last-of-line words, and zero-pads the final partial word of each line.

---
 rtl/rgb24_stream_packer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rgb24_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb24_stream_packer
//  Description : Packs a 24-bit RGB pixel stream densely (little-endian) into
//                128-bit words with SOF/last markers, through a FWFT FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb24_stream_packer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_WIDTH = 12
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [23:0]            pixel_i,
    input  logic                   pixel_valid_i,
    input  logic                   line_end_i,
    input  logic                   frame_start_i,
    output logic [127:0]           word_o,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic                   word_last_o,
    output logic                   word_sof_o,
    output logic [COUNT_WIDTH-1:0] line_pixels_o,
    output logic                   overflow_o
);

    localparam int c_MEM_DEPTH = FIFO_DEPTH - 1;
    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Packing state
    // ------------------------------------------------------------------
    logic [119:0]           r_acc;
    logic [3:0]             r_fill;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] r_line_pixels;
    logic                   r_flush_pending;
    logic [23:0]            r_flush_data;
    logic                   r_sof_pending;

    logic [119:0]           w_acc_base;
    logic [3:0]             w_fill_base;
    logic [COUNT_WIDTH-1:0] w_cnt_base;
    logic [COUNT_WIDTH-1:0] w_cnt_inc;
    logic                   w_sof_base;
    logic                   w_flush_now;
    logic [143:0]           w_combined;
    logic [4:0]             w_fill_sum;
    logic                   w_complete;
    logic                   w_line_end;
    logic                   w_push;
    logic                   w_push_last;
    logic [127:0]           w_push_data;
    logic [129:0]           w_push_word;
    logic                   w_set_flush;
    logic [23:0]            w_flush_data_next;

    always_comb begin
        // A frame start wipes the line state before the coincident pixel is used
        w_acc_base  = frame_start_i ? '0 : r_acc;
        w_fill_base = frame_start_i ? '0 : r_fill;
        w_cnt_base  = frame_start_i ? '0 : r_cnt;
        w_sof_base  = frame_start_i | r_sof_pending;
        w_flush_now = r_flush_pending & ~frame_start_i;

        w_combined  = {24'b0, w_acc_base} | ({120'b0, pixel_i} << {w_fill_base, 3'b000});
        w_fill_sum  = {1'b0, w_fill_base} + 5'd3;
        w_complete  = pixel_valid_i & w_fill_sum[4];
        w_line_end  = pixel_valid_i & line_end_i;
        w_cnt_inc   = (w_cnt_base == {COUNT_WIDTH{1'b1}}) ? w_cnt_base : w_cnt_base + 1'b1;

        w_push            = 1'b0;
        w_push_last       = 1'b0;
        w_push_data       = '0;
        w_set_flush       = 1'b0;
        w_flush_data_next = r_flush_data;

        if (w_flush_now) begin
            w_push      = 1'b1;
            w_push_last = 1'b1;
            w_push_data = {104'b0, r_flush_data};
        end

        if (w_complete) begin
            w_push      = 1'b1;
            w_push_data = w_combined[127:0];
            if (line_end_i) begin
                if (w_fill_sum[3:0] == 4'd0) begin
                    w_push_last = 1'b1;
                end else begin
                    w_push_last       = 1'b0;
                    w_set_flush       = 1'b1;
                    w_flush_data_next = {8'b0, w_combined[143:128]};
                end
            end else begin
                w_push_last = 1'b0;
            end
        end else if (w_line_end) begin
            // A one-pixel line landing on a flush cycle is deferred one cycle
            if (w_flush_now) begin
                w_set_flush       = 1'b1;
                w_flush_data_next = w_combined[23:0];
            end else begin
                w_push      = 1'b1;
                w_push_last = 1'b1;
                w_push_data = w_combined[127:0];
            end
        end

        w_push_word = {w_sof_base, w_push_last, w_push_data};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_acc           <= '0;
            r_fill          <= '0;
            r_cnt           <= '0;
            r_line_pixels   <= '0;
            r_flush_pending <= 1'b0;
            r_flush_data    <= '0;
            r_sof_pending   <= 1'b0;
        end else begin
            if (w_line_end) begin
                r_acc         <= '0;
                r_fill        <= '0;
                r_cnt         <= '0;
                r_line_pixels <= w_cnt_inc;
            end else if (pixel_valid_i) begin
                r_acc  <= w_complete ? {104'b0, w_combined[143:128]} : w_combined[119:0];
                r_fill <= w_fill_sum[3:0];
                r_cnt  <= w_cnt_inc;
            end else begin
                r_acc  <= w_acc_base;
                r_fill <= w_fill_base;
                r_cnt  <= w_cnt_base;
            end
            r_flush_pending <= w_set_flush;
            if (w_set_flush) begin
                r_flush_data <= w_flush_data_next;
            end
            r_sof_pending <= w_push ? 1'b0 : w_sof_base;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: registered head stage plus FIFO_DEPTH-1 storage slots
    // ------------------------------------------------------------------
    logic [129:0]       r_mem [c_MEM_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_mem_count;
    logic               r_out_valid;
    logic [129:0]       r_out;
    logic               r_overflow;

    logic               w_pop;
    logic               w_full;
    logic               w_push_ok;
    logic               w_out_load;
    logic               w_mem_rd;
    logic               w_bypass;
    logic               w_mem_wr;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    always_comb begin
        w_pop        = r_out_valid & word_ready_i;
        w_full       = r_out_valid & (r_mem_count == c_PTR_W'(c_MEM_DEPTH));
        w_push_ok    = w_push & (~w_full | w_pop);
        w_out_load   = ~r_out_valid | w_pop;
        w_mem_rd     = w_out_load & (r_mem_count != '0);
        w_bypass     = w_out_load & (r_mem_count == '0) & w_push_ok;
        w_mem_wr     = w_push_ok & ~w_bypass;
        w_wr_ptr_nxt = (r_wr_ptr == c_PTR_W'(c_MEM_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == c_PTR_W'(c_MEM_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_mem_rd) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_mem_wr, w_mem_rd})
                2'b10:   r_mem_count <= r_mem_count + 1'b1;
                2'b01:   r_mem_count <= r_mem_count - 1'b1;
                default: r_mem_count <= r_mem_count;
            endcase
            // Head only changes when empty or consumed, so it holds while stalled
            if (w_out_load) begin
                if (w_mem_rd) begin
                    r_out       <= r_mem[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else if (w_bypass) begin
                    r_out       <= w_push_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (w_push & ~w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign word_o        = r_out[127:0];
    assign word_last_o   = r_out[128];
    assign word_sof_o    = r_out[129];
    assign word_valid_o  = r_out_valid;
    assign line_pixels_o = r_line_pixels;
    assign overflow_o    = r_overflow;

endmodule
`default_nettype wire
